aurora_tx_frame_mux: RTL and testbench
======================================

Name: aurora_tx_frame_mux

Overview:
- Multi-channel TX front end for the Aurora master core. It merges NUM_CH independent user framed streams (sop/eop/mod/valid) into one active-low LocalLink TX stream (sop_n/eop_n/rem/src_rdy_n/dst_rdy_n).
- Per-channel frame buffering plus whole-frame round-robin arbitration. An optional channel-ID header beat precedes each frame so the far end can demultiplex.
- Single clock (Aurora user clock). Replaces the single-channel TX FIFO controller where several producers share one link.

Parameters:
- DATA_W, 64, data beat width in bits (multiple of 8).
- MOD_W, 3, mod/rem width, equal to log2(DATA_W/8).
- NUM_CH, 4, number of user channels (2..16).
- FIFO_DEPTH, 512, beats per channel FIFO (power of 2). Maximum frame length is FIFO_DEPTH beats, header excluded.
- HDR_EN, 1, 1 inserts a header beat per frame; 0 passes frames unmodified.

Ports:
- user_clk  in  1  Aurora user clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_data_i  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]; byte 0 is the MSB byte.
- ch_sop_i  in  NUM_CH  start-of-frame, per channel.
- ch_eop_i  in  NUM_CH  end-of-frame, per channel.
- ch_mod_i  in  NUM_CH*MOD_W  valid bytes in the eop beat; 0 means all bytes valid.
- ch_wren_i  in  NUM_CH  write strobe, per channel.
- ch_full_o  out  NUM_CH  channel FIFO full.
- ch_ovf_o  out  NUM_CH  sticky overflow flag.
- tx_data_o  out  DATA_W  LocalLink data.
- tx_sop_n_o  out  1  start of frame, active low.
- tx_eop_n_o  out  1  end of frame, active low.
- tx_rem_o  out  MOD_W  index of the last valid byte in the eop beat.
- tx_src_rdy_n_o  out  1  source ready, active low.
- tx_dst_rdy_n_i  in  1  destination ready, active low.
- tx_frame_cnt_o  out  32  frames fully sent; wraps at 2^32.

Behaviour:
- Reset:
  - All outputs are registered.
  - tx_src_rdy_n_o, tx_sop_n_o and tx_eop_n_o = 1.
  - tx_data_o = 0, tx_rem_o = 0, ch_full_o = 0, ch_ovf_o = 0, tx_frame_cnt_o = 0.
  - FIFOs flushed, frame counters 0, round-robin pointer = channel NUM_CH-1, FSM in IDLE.
- Write side:
  - A beat is stored when ch_wren_i[c]=1 and ch_full_o[c]=0.
  - A write while full is dropped and sets ch_ovf_o[c], which holds until reset.
- Frame counter:
  - Per-channel frm_cnt[c] increments when an eop beat is written and decrements when an eop beat is read.
  - Both events in the same cycle leave it unchanged.
  - Its width is clog2(FIFO_DEPTH)+1 bits.
- Arbitration: only channels with frm_cnt>0 are eligible. Because a granted channel always holds a complete frame, the output never underruns mid-frame.
- FSM states: IDLE, HDR, DATA.
  - IDLE: if any channel is eligible, grant the first eligible channel after the last granted one (round robin). Go to HDR if HDR_EN=1, else DATA.
  - HDR: drive the header beat with sop_n=0 and eop_n=1.
    - Header data: bits [DATA_W-1 -: 8] = 8'hA5, bits [7:0] = channel ID, all other bits 0.
    - Move to DATA when the beat is accepted.
  - DATA: stream FIFO beats.
    - With HDR_EN=1, sop_n is driven 1 on data beats; with HDR_EN=0 it follows the stored sop.
    - On acceptance of the stored eop beat: eop_n=0; tx_rem_o = (mod==0) ? DATA_W/8-1 : mod-1; increment tx_frame_cnt_o; go to IDLE.
- Handshake:
  - A beat transfers when tx_src_rdy_n_o=0 and tx_dst_rdy_n_i=0.
  - While tx_dst_rdy_n_i=1, every output holds stable.
  - Within a frame, src_rdy_n stays low continuously; there are no bubbles.
- Latency: from idle with dst ready, tx_src_rdy_n_o falls 2 clocks after the clock edge that writes the eop beat. There is a minimum of 1 idle cycle between frames.
- Single-beat frame (sop and eop together) is legal. With HDR_EN=0 the output beat has sop_n=eop_n=0.
- Reset asserted mid-frame aborts the frame. Outputs return to reset values at the next edge; no eop is generated.
- Oversize or overflowed frame: if a channel is full with frm_cnt=0, that channel stalls until reset (flagged by ch_ovf_o). Other channels are unaffected.

Decomposition:
- Package aurora_intf_pkg holds:
  - HDR_MAGIC = 8'hA5;
  - the FSM state enum {IDLE, HDR, DATA};
  - a clog2 function;
  - a mod-to-rem conversion function.
- Sub-module aurora_sync_frame_fifo: single-clock, show-ahead, stores {sop,eop,mod,data}, with full/empty and an eop-beat counter. Instantiated NUM_CH times in a generate loop.

Test Plan:
- ch0 writes a 3-beat frame D0..D2, eop mod=5, HDR_EN=1 -> header 0xA500...0000; then D0, D1, D2 with eop_n=0 and rem=4; tx_frame_cnt_o=1.
- ch1 and ch3 each write a 2-beat frame in the same cycle, then ch1 writes a second frame -> output order ch1, ch3, ch1; header IDs 01, 03, 01.
- tx_dst_rdy_n_i held high for 5 cycles on the second data beat -> tx_data_o, sop_n, eop_n and rem are unchanged all 5 cycles; no beat is lost or duplicated.
- ch2 is written 513 beats with no eop, FIFO_DEPTH=512 -> ch_full_o[2]=1 after beat 512; beat 513 is dropped; ch_ovf_o[2]=1; ch0 traffic continues to flow.
- reset is pulsed during beat 2 of a 4-beat frame -> the next edge gives src_rdy_n=1, ch_ovf_o=0, tx_frame_cnt_o=0; a new frame afterwards sends correctly.
- HDR_EN=0, single-beat frame with sop=eop=1 and mod=0 -> one output beat with sop_n=eop_n=0 and rem=7.

Source files
------------

// File: rtl/aurora_intf_pkg.sv
// aurora_intf_pkg: shared constants, FSM states and helpers for the Aurora TX frame mux
package aurora_intf_pkg;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int mod2rem(input int mod, input int bytes);
    return (mod == 0) ? bytes - 1 : mod - 1;
  endfunction
endpackage

// File: rtl/aurora_sync_frame_fifo.sv
// aurora_sync_frame_fifo: show-ahead single-clock beat FIFO that also counts stored eop beats
module aurora_sync_frame_fifo
  import aurora_intf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MOD_W  = 3,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sop,
  input  logic                     wr_eop,
  input  logic [MOD_W-1:0]         wr_mod,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic                     rd_sop,
  output logic                     rd_eop,
  output logic [MOD_W-1:0]         rd_mod,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     ovf,
  output logic [clog2(DEPTH):0]    frm_cnt
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + MOD_W + 2;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic wr_ok, rd_ok;
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & (cnt != '0);
  assign cnt_nxt = cnt + CW'(wr_ok) - CW'(rd_ok);
  assign {rd_sop, rd_eop, rd_mod, rd_data} = mem[rp];
  // storage needs no flush: reset only rewinds pointers and counts
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= {wr_sop, wr_eop, wr_mod, wr_data};
  always_ff @(posedge clk)
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      frm_cnt <= '0;
      full    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      wp      <= wp + AW'(wr_ok);
      rp      <= rp + AW'(rd_ok);
      cnt     <= cnt_nxt;
      frm_cnt <= frm_cnt + CW'(wr_ok & wr_eop) - CW'(rd_ok & rd_eop);
      full    <= cnt_nxt == CW'(DEPTH);
      ovf     <= ovf | (wr_en & full);
    end
endmodule

// File: rtl/aurora_tx_frame_mux.sv
// aurora_tx_frame_mux: buffers NUM_CH framed streams and round-robins whole frames onto one LocalLink TX port
module aurora_tx_frame_mux
  import aurora_intf_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MOD_W      = 3,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 512,
  parameter int HDR_EN     = 1
) (
  input  logic                     user_clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]        ch_sop_i,
  input  logic [NUM_CH-1:0]        ch_eop_i,
  input  logic [NUM_CH*MOD_W-1:0]  ch_mod_i,
  input  logic [NUM_CH-1:0]        ch_wren_i,
  output logic [NUM_CH-1:0]        ch_full_o,
  output logic [NUM_CH-1:0]        ch_ovf_o,
  output logic [DATA_W-1:0]        tx_data_o,
  output logic                     tx_sop_n_o,
  output logic                     tx_eop_n_o,
  output logic [MOD_W-1:0]         tx_rem_o,
  output logic                     tx_src_rdy_n_o,
  input  logic                     tx_dst_rdy_n_i,
  output logic [31:0]              tx_frame_cnt_o
);
  localparam int GW = clog2(NUM_CH);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  state_t state, nxt;
  logic [GW-1:0] gnt, nxt_gnt;
  logic found, load;
  logic [NUM_CH-1:0] elig, rd, f_sop, f_eop;
  logic [MOD_W-1:0] f_mod [NUM_CH];
  logic [DATA_W-1:0] f_data [NUM_CH];
  logic [CW-1:0] frm_cnt [NUM_CH];
  logic [DATA_W-1:0] hdr;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    aurora_sync_frame_fifo #(.DATA_W(DATA_W), .MOD_W(MOD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(user_clk), .rst(reset),
      .wr_en(ch_wren_i[c]), .wr_sop(ch_sop_i[c]), .wr_eop(ch_eop_i[c]),
      .wr_mod(ch_mod_i[c*MOD_W +: MOD_W]), .wr_data(ch_data_i[c*DATA_W +: DATA_W]),
      .rd_en(rd[c]), .rd_sop(f_sop[c]), .rd_eop(f_eop[c]), .rd_mod(f_mod[c]), .rd_data(f_data[c]),
      .full(ch_full_o[c]), .ovf(ch_ovf_o[c]), .frm_cnt(frm_cnt[c]));
    assign elig[c] = frm_cnt[c] != '0;
    assign rd[c] = state == DATA && load && gnt == GW'(c);
  end
  // the output register may take a new beat when empty or when its beat is being accepted
  assign load = tx_src_rdy_n_o | ~tx_dst_rdy_n_i;
  always_comb begin
    nxt_gnt = gnt;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++)
      if (!found && elig[(int'(gnt) + i) % NUM_CH]) begin
        found = 1'b1;
        nxt_gnt = GW'((int'(gnt) + i) % NUM_CH);
      end
  end
  always_comb begin
    hdr = '0;
    hdr[DATA_W-1 -: 8] = HDR_MAGIC;
    hdr[7:0] = 8'(gnt);
  end
  // arbitrate only once the previous eop has left, guaranteeing an idle gap between frames
  always_comb begin
    nxt = state;
    if (state == IDLE && tx_src_rdy_n_o && found) nxt = (HDR_EN != 0) ? HDR : DATA;
    if (state == HDR && load) nxt = DATA;
    if (state == DATA && load && f_eop[gnt]) nxt = IDLE;
  end
  always_ff @(posedge user_clk)
    if (reset) begin
      state          <= IDLE;
      gnt            <= GW'(NUM_CH - 1);
      tx_data_o      <= '0;
      tx_sop_n_o     <= 1'b1;
      tx_eop_n_o     <= 1'b1;
      tx_rem_o       <= '0;
      tx_src_rdy_n_o <= 1'b1;
      tx_frame_cnt_o <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && tx_src_rdy_n_o && found) gnt <= nxt_gnt;
      if (!tx_src_rdy_n_o && !tx_dst_rdy_n_i && !tx_eop_n_o) tx_frame_cnt_o <= tx_frame_cnt_o + 32'd1;
      if (load) begin
        tx_src_rdy_n_o <= state == IDLE;
        tx_sop_n_o     <= (state == DATA) ? (HDR_EN != 0 || !f_sop[gnt]) : state != HDR;
        tx_eop_n_o     <= state != DATA || !f_eop[gnt];
        if (state != IDLE) tx_data_o <= (state == HDR) ? hdr : f_data[gnt];
        if (state == DATA) tx_rem_o <= f_eop[gnt] ? MOD_W'(mod2rem(int'(f_mod[gnt]), DATA_W / 8)) : '0;
      end
    end
endmodule

// File: tb/tb_aurora_tx_frame_mux.sv
// tb_aurora_tx_frame_mux: scoreboard bench for the frame mux, with and without header insertion
module tb_aurora_tx_frame_mux;
  localparam int NC = 4;
  localparam int DEPTH = 512;
  typedef struct packed {logic [63:0] d; logic sop; logic eop; logic [2:0] rem;} beat_t;

  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  logic [255:0] ch_data = '0;
  logic [3:0] ch_sop = '0, ch_eop = '0, ch_wren = '0, ch_full, ch_ovf;
  logic [11:0] ch_mod = '0;
  logic [63:0] tx_data;
  logic tx_sop_n, tx_eop_n, tx_src_rdy_n, tx_dst_rdy_n = 0;
  logic [2:0] tx_rem;
  logic [31:0] frame_cnt;

  logic [127:0] b_data = '0;
  logic [1:0] b_sop = '0, b_eop = '0, b_wren = '0, b_full, b_ovf;
  logic [5:0] b_mod = '0;
  logic [63:0] b_tx_data;
  logic b_sop_n, b_eop_n, b_src_rdy_n, b_dst_rdy_n = 0;
  logic [2:0] b_rem;
  logic [31:0] b_frame_cnt;

  aurora_tx_frame_mux dut (
    .user_clk(clk), .reset(reset), .ch_data_i(ch_data), .ch_sop_i(ch_sop), .ch_eop_i(ch_eop),
    .ch_mod_i(ch_mod), .ch_wren_i(ch_wren), .ch_full_o(ch_full), .ch_ovf_o(ch_ovf),
    .tx_data_o(tx_data), .tx_sop_n_o(tx_sop_n), .tx_eop_n_o(tx_eop_n), .tx_rem_o(tx_rem),
    .tx_src_rdy_n_o(tx_src_rdy_n), .tx_dst_rdy_n_i(tx_dst_rdy_n), .tx_frame_cnt_o(frame_cnt));

  aurora_tx_frame_mux #(.NUM_CH(2), .FIFO_DEPTH(8), .HDR_EN(0)) dut_b (
    .user_clk(clk), .reset(reset), .ch_data_i(b_data), .ch_sop_i(b_sop), .ch_eop_i(b_eop),
    .ch_mod_i(b_mod), .ch_wren_i(b_wren), .ch_full_o(b_full), .ch_ovf_o(b_ovf),
    .tx_data_o(b_tx_data), .tx_sop_n_o(b_sop_n), .tx_eop_n_o(b_eop_n), .tx_rem_o(b_rem),
    .tx_src_rdy_n_o(b_src_rdy_n), .tx_dst_rdy_n_i(b_dst_rdy_n), .tx_frame_cnt_o(b_frame_cnt));

  int chk_cnt = 0, pass_cnt = 0;
  beat_t qa [NC][$];
  beat_t qb [$];
  int frames_ready [NC];
  int exp_frames = 0, exp_frames_b = 0;
  int order_log [$];
  bit in_frame = 0, prev_hold = 0, rand_dst = 0;
  int cur = 0;
  logic [63:0] p_data;
  logic [5:0] p_ctl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [2:0] rem_of(input logic [2:0] m);
    return (m == 0) ? 3'd7 : m - 3'd1;
  endfunction

  function automatic void model_write(input int c, input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
    beat_t b;
    if (qa[c].size() >= DEPTH) return;
    b.d = d; b.sop = s; b.eop = e; b.rem = rem_of(m);
    qa[c].push_back(b);
    if (e) begin frames_ready[c]++; exp_frames++; end
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] en, input logic [255:0] d, input logic [3:0] s, input logic [3:0] e, input logic [11:0] m);
    ch_wren = en; ch_data = d; ch_sop = s; ch_eop = e; ch_mod = m;
    for (int c = 0; c < NC; c++) if (en[c]) model_write(c, d[c*64 +: 64], s[c], e[c], m[c*3 +: 3]);
    cyc();
    ch_wren = '0;
  endtask

  task automatic wr1(input int c, input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
    logic [255:0] dv = '0;
    logic [11:0] mv = '0;
    dv[c*64 +: 64] = d;
    mv[c*3 +: 3] = m;
    drive(4'(1) << c, dv, 4'(s) << c, 4'(e) << c, mv);
  endtask

  task automatic wr_frame(input int c, input int n, input logic [2:0] m, input logic [63:0] base);
    for (int i = 0; i < n; i++) wr1(c, base + 64'(i), i == 0, i == n - 1, m);
  endtask

  task automatic wr_b(input int c, input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
    beat_t b;
    b.d = d; b.sop = s; b.eop = e; b.rem = rem_of(m);
    qb.push_back(b);
    if (e) exp_frames_b++;
    b_wren = 2'(1) << c; b_sop = 2'(s) << c; b_eop = 2'(e) << c;
    b_data = '0; b_data[c*64 +: 64] = d;
    b_mod = '0; b_mod[c*3 +: 3] = m;
    cyc();
    b_wren = '0;
  endtask

  task automatic wait_beat(input logic [63:0] v);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++)
      if (!tx_src_rdy_n && tx_data == v) ok = 1; else cyc();
    if (!ok) chk("wait_beat_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      cyc();
      done = !in_frame && qb.size() == 0;
      for (int c = 0; c < NC; c++) if (frames_ready[c] != 0) done = 0;
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    reset = 1;
    for (int c = 0; c < NC; c++) begin qa[c].delete(); frames_ready[c] = 0; end
    qb.delete();
    exp_frames = 0;
    exp_frames_b = 0;
    cyc();
    reset = 0;
  endtask

  always @(negedge clk) begin : mon_a
    beat_t b;
    int id;
    if (reset) begin
      in_frame = 0;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_data", tx_data, p_data);
        chk("hold_ctl", {58'h0, tx_src_rdy_n, tx_sop_n, tx_eop_n, tx_rem}, {58'h0, p_ctl});
      end
      if (in_frame) chk("no_bubble", tx_src_rdy_n, 0);
      if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
        if (!in_frame) begin
          id = int'(tx_data[7:0]);
          chk("hdr_ctl", {tx_sop_n, tx_eop_n}, 2'b01);
          chk("hdr_upper", {8'h0, tx_data[63:8]}, {8'h0, 8'hA5, 48'h0});
          chk("hdr_id_ready", id < NC && frames_ready[id % NC] > 0, 1);
          if (id < NC && frames_ready[id] > 0) begin
            in_frame = 1;
            cur = id;
            order_log.push_back(id);
          end
        end else if (qa[cur].size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          b = qa[cur].pop_front();
          chk("data", tx_data, b.d);
          chk("data_ctl", {tx_sop_n, tx_eop_n}, {1'b1, !b.eop});
          if (b.eop) begin
            chk("rem", tx_rem, b.rem);
            frames_ready[cur]--;
            in_frame = 0;
          end
        end
      end
      prev_hold = !tx_src_rdy_n && tx_dst_rdy_n;
      p_data = tx_data;
      p_ctl = {tx_src_rdy_n, tx_sop_n, tx_eop_n, tx_rem};
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t b;
    if (!reset && !b_src_rdy_n && !b_dst_rdy_n) begin
      if (qb.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        b = qb.pop_front();
        chk("b_data", b_tx_data, b.d);
        chk("b_ctl", {b_sop_n, b_eop_n}, {!b.sop, !b.eop});
        if (b.eop) chk("b_rem", b_rem, b.rem);
      end
    end
  end

  always @(posedge clk)
    if (rand_dst) begin
      #1;
      tx_dst_rdy_n = ($urandom_range(3) == 0);
    end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] dv;
    logic [11:0] mv;
    logic [3:0] en, sv, ev;
    int left [NC];
    int idx [NC];
    bit busy;
    for (int c = 0; c < NC; c++) begin frames_ready[c] = 0; left[c] = 0; idx[c] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src", tx_src_rdy_n, 1);
    chk("rst_sop_eop", {tx_sop_n, tx_eop_n}, 2'b11);
    chk("rst_data", tx_data, 0);
    chk("rst_rem", tx_rem, 0);
    chk("rst_full_ovf", {ch_full, ch_ovf}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_b_src", b_src_rdy_n, 1);
    reset = 0;
    cyc();

    wr1(0, 64'hD0D0_0000_0000_0000, 1, 0, 0);
    wr1(0, 64'hD1D1_0000_0000_0001, 0, 0, 0);
    wr1(0, 64'hD2D2_0000_0000_0002, 0, 1, 5);
    chk("lat_e0", tx_src_rdy_n, 1);
    cyc();
    chk("lat_e1", tx_src_rdy_n, 1);
    cyc();
    chk("lat_e2", tx_src_rdy_n, 0);
    chk("lat_hdr", tx_data, 64'hA500_0000_0000_0000);
    wait_drain();
    chk("frame_cnt_t1", frame_cnt, 32'(exp_frames));

    order_log.delete();
    drive(4'b1010, {64'hB0, 64'h0, 64'hA0, 64'h0}, 4'b1010, 4'b0000, 12'h0);
    drive(4'b1010, {64'hB1, 64'h0, 64'hA1, 64'h0}, 4'b0000, 4'b1010, {3'd0, 3'd0, 3'd2, 3'd0});
    wr_frame(1, 2, 3'd7, 64'hC0);
    wait_drain();
    chk("order_size", order_log.size(), 3);
    chk("order_0", order_log.size() > 0 ? order_log[0] : -1, 1);
    chk("order_1", order_log.size() > 1 ? order_log[1] : -1, 3);
    chk("order_2", order_log.size() > 2 ? order_log[2] : -1, 1);
    chk("frame_cnt_t2", frame_cnt, 32'(exp_frames));

    wr_frame(0, 4, 3'd0, 64'h1111_0000_0000_0000);
    wait_beat(64'h1111_0000_0000_0001);
    tx_dst_rdy_n = 1;
    repeat (5) cyc();
    chk("stall_data", tx_data, 64'h1111_0000_0000_0001);
    chk("stall_src", tx_src_rdy_n, 0);
    tx_dst_rdy_n = 0;
    wait_drain();
    chk("frame_cnt_t3", frame_cnt, 32'(exp_frames));

    for (int i = 0; i < DEPTH + 1; i++) begin
      wr1(2, 64'(i), i == 0, 0, 0);
      chk("full_ch2", ch_full[2], qa[2].size() == DEPTH);
    end
    chk("ovf_ch2", ch_ovf, 4'b0100);
    wr_frame(0, 3, 3'd2, 64'h2222_0000_0000_0000);
    wait_drain();
    chk("frame_cnt_t4", frame_cnt, 32'(exp_frames));

    wr_frame(1, 4, 3'd1, 64'h3333_0000_0000_0000);
    wait_beat(64'h3333_0000_0000_0001);
    do_reset();
    chk("midrst_src", tx_src_rdy_n, 1);
    chk("midrst_ovf_full", {ch_ovf, ch_full}, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    wr_frame(3, 2, 3'd4, 64'h4444_0000_0000_0000);
    wait_drain();
    chk("frame_cnt_t5", frame_cnt, 32'(exp_frames));

    rand_dst = 1;
    for (int t = 0; t < 400; t++) begin
      en = '0; sv = '0; ev = '0; dv = '0; mv = '0;
      busy = 0;
      for (int c = 0; c < NC; c++) begin
        if (left[c] > 0 || (t < 250 && $urandom_range(2) == 0)) begin
          if (left[c] == 0) begin left[c] = $urandom_range(1, 6); idx[c] = 0; end
          if ($urandom_range(1) == 0) begin
            en[c] = 1;
            sv[c] = idx[c] == 0;
            ev[c] = left[c] == 1;
            dv[c*64 +: 64] = {$urandom, $urandom};
            mv[c*3 +: 3] = 3'($urandom_range(7));
            left[c]--;
            idx[c]++;
          end
        end
        if (left[c] > 0) busy = 1;
      end
      drive(en, dv, sv, ev, mv);
      if (t >= 250 && !busy) break;
    end
    rand_dst = 0;
    cyc();
    tx_dst_rdy_n = 0;
    wait_drain();
    chk("frame_cnt_rand", frame_cnt, 32'(exp_frames));

    wr_b(0, 64'h5555_6666_7777_8888, 1, 1, 3'd0);
    wr_b(1, 64'h9000_0000_0000_0000, 1, 0, 3'd0);
    wr_b(1, 64'h9000_0000_0000_0001, 0, 0, 3'd0);
    wr_b(1, 64'h9000_0000_0000_0002, 0, 1, 3'd3);
    wait_drain();
    chk("b_frame_cnt", b_frame_cnt, 32'(exp_frames_b));
    chk("b_ovf", b_ovf, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
